// File: rtl/decode_pkg.sv
// decode_pkg: control-word layout, opcodes, FSM states and exception causes for decode_stage
package decode_pkg;
    typedef struct packed {
        logic       reg2loc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       branchtoreg;
        logic       eret;
        logic [1:0] aluop;
        logic [1:0] alusrc;
    } ctrl_t;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_CBZ  = 11'b101_1010_0???;
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_MRS  = 11'h6A9;
    localparam logic [10:0] OP_ERET = 11'h6B4;
    localparam logic [10:0] OP_BR   = 11'h6B0;
    typedef enum logic [1:0] {ST_NORMAL, ST_HANDLER, ST_HALT} state_t;
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_INVALID = 2'b01;
    localparam logic [1:0] CAUSE_ERET    = 2'b10;
    localparam logic [1:0] CAUSE_NESTED  = 2'b11;
endpackage

// File: rtl/decode_core.sv
// decode_core: combinational opcode -> control-word table; BR (6B0) decodes only with DECODE_STAGE_BR_EN
module decode_core import decode_pkg::*; (
    input  logic [10:0] op,
    output ctrl_t       ctrl,
    output logic        invalid,
    output logic        is_eret
);
    always_comb begin
        ctrl    = '0;
        invalid = 1'b0;
        is_eret = 1'b0;
        casez (op)
            OP_LDUR: begin
                ctrl.alusrc   = 2'b01;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
            end
            OP_STUR: begin
                ctrl.reg2loc  = 1'b1;
                ctrl.alusrc   = 2'b01;
                ctrl.memwrite = 1'b1;
            end
            OP_CBZ: begin
                ctrl.reg2loc = 1'b1;
                ctrl.branch  = 1'b1;
                ctrl.aluop   = 2'b01;
            end
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = 2'b10;
            end
            OP_MRS: begin
                ctrl.reg2loc  = 1'b1;
                ctrl.alusrc   = 2'b10;
                ctrl.regwrite = 1'b1;
            end
            OP_ERET: begin
                ctrl.branch = 1'b1;
                ctrl.eret   = 1'b1;
                ctrl.aluop  = 2'b01;
                is_eret     = 1'b1;
            end
`ifdef DECODE_STAGE_BR_EN
            OP_BR: begin
                ctrl.branch      = 1'b1;
                ctrl.branchtoreg = 1'b1;
                ctrl.aluop       = 2'b01;
            end
`endif
            default: invalid = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with exception FSM and saturating exception counter
// BR decode is enabled by defining DECODE_STAGE_BR_EN.
module decode_stage import decode_pkg::*; #(
    parameter int unsigned CNT_W          = 8,
    parameter bit          HALT_ON_NESTED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      op,
    output logic             out_valid,
    input  logic             out_ready,
    output ctrl_t            ctrl,
    output logic             exc_req,
    output logic [1:0]       exc_cause,
    output logic [CNT_W-1:0] exc_count,
    output logic             in_handler,
    output logic             halted
);
    state_t     state, state_n;
    ctrl_t      dec_ctrl, ctrl_n;
    logic       dec_invalid, dec_eret, accept, take, exc_n;
    logic [1:0] cause_n;

    decode_core u_core (
        .op      (op),
        .ctrl    (dec_ctrl),
        .invalid (dec_invalid),
        .is_eret (dec_eret)
    );

    assign in_handler = state == ST_HANDLER;
    assign halted     = state == ST_HALT;
    assign in_ready   = (!out_valid || out_ready) && !halted;
    assign accept     = in_valid && in_ready;
    // a flushed op is discarded before it can except or move the FSM
    assign take       = accept && !flush;

    always_comb begin
        state_n = state;
        exc_n   = 1'b0;
        cause_n = CAUSE_NONE;
        ctrl_n  = dec_ctrl;
        if (take) begin
            if (dec_invalid) begin
                ctrl_n  = '0;
                exc_n   = 1'b1;
                cause_n = in_handler ? CAUSE_NESTED : CAUSE_INVALID;
                state_n = (in_handler && HALT_ON_NESTED) ? ST_HALT : ST_HANDLER;
            end else if (dec_eret) begin
                if (in_handler) begin
                    state_n = ST_NORMAL;
                end else begin
                    ctrl_n  = '0;
                    exc_n   = 1'b1;
                    cause_n = CAUSE_ERET;
                    state_n = ST_HANDLER;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_NORMAL;
            out_valid <= 1'b0;
            ctrl      <= '0;
            exc_req   <= 1'b0;
            exc_cause <= CAUSE_NONE;
            exc_count <= '0;
        end else begin
            state   <= state_n;
            exc_req <= exc_n;
            if (exc_n) begin
                exc_cause <= cause_n;
                if (exc_count != '1) exc_count <= exc_count + 1'b1;
            end
            if (flush) begin
                out_valid <= 1'b0;
                ctrl      <= '0;
            end else if (accept) begin
                out_valid <= 1'b1;
                ctrl      <= ctrl_n;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (default and CNT_W=2/no-halt builds)
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [10:0] op = '0;
    logic        in_ready, out_valid, exc_req, in_handler, halted;
    logic [11:0] ctrl;
    logic [1:0]  exc_cause;
    logic [7:0]  exc_count;
    logic        in_ready2, out_valid2, exc_req2, in_handler2, halted2;
    logic [11:0] ctrl2;
    logic [1:0]  exc_cause2;
    logic [1:0]  exc_count2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl), .exc_req(exc_req),
        .exc_cause(exc_cause), .exc_count(exc_count), .in_handler(in_handler), .halted(halted)
    );

    decode_stage #(.CNT_W(2), .HALT_ON_NESTED(1'b0)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .out_valid(out_valid2), .out_ready(out_ready), .ctrl(ctrl2), .exc_req(exc_req2),
        .exc_cause(exc_cause2), .exc_count(exc_count2), .in_handler(in_handler2), .halted(halted2)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (2) cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (ctrl !== 12'h000) begin bad++; $display("FAIL reset_ctrl got=%h want=000", ctrl); end
        total++; if (exc_req !== 1'b0 || exc_cause !== 2'b00) begin bad++; $display("FAIL reset_exc got=%b/%b want=0/00", exc_req, exc_cause); end
        total++; if (exc_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", exc_count); end
        total++; if (in_handler !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL reset_state got=%b%b want=00", in_handler, halted); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        do_reset();
    endtask

    task automatic test_stream;
        logic [10:0] sops [10] = '{11'h7C2, 11'h7C0, 11'h458, 11'h5A3, 11'h658, 11'h450, 11'h550, 11'h6A9, 11'h5A0, 11'h5A7};
        logic [11:0] sexp [10] = '{12'h701, 12'h881, 12'h208, 12'h844, 12'h208, 12'h208, 12'h208, 12'hA02, 12'h844, 12'h844};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            op = sops[i];
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, in_ready); end
            cyc();
            total++; if (out_valid !== 1'b1 || ctrl !== sexp[i]) begin bad++; $display("FAIL stream_ctrl[%0d] op=%h got=%b/%h want=1/%h", i, sops[i], out_valid, ctrl, sexp[i]); end
            total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL stream_exc[%0d] got=%b want=0", i, exc_req); end
        end
        in_valid = 1'b0;
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", out_valid); end
        do_reset();
    endtask

    task automatic test_handler;
        in_valid = 1'b1;
        op = 11'h000;
        cyc();
        total++; if (out_valid !== 1'b1 || ctrl !== 12'h000) begin bad++; $display("FAIL inv_ctrl got=%b/%h want=1/000", out_valid, ctrl); end
        total++; if (exc_req !== 1'b1 || exc_cause !== 2'b01) begin bad++; $display("FAIL inv_exc got=%b/%b want=1/01", exc_req, exc_cause); end
        total++; if (in_handler !== 1'b1 || exc_count !== 8'd1) begin bad++; $display("FAIL inv_state got=%b/%0d want=1/1", in_handler, exc_count); end
        op = 11'h6B4;
        cyc();
        total++; if (ctrl !== 12'h054 || exc_req !== 1'b0) begin bad++; $display("FAIL eret_ctrl got=%h/%b want=054/0", ctrl, exc_req); end
        total++; if (in_handler !== 1'b0) begin bad++; $display("FAIL eret_exit got=%b want=0", in_handler); end
        cyc();
        total++; if (ctrl !== 12'h000 || exc_req !== 1'b1 || exc_cause !== 2'b10) begin bad++; $display("FAIL eret_outside got=%h/%b/%b want=000/1/10", ctrl, exc_req, exc_cause); end
        total++; if (in_handler !== 1'b1 || exc_count !== 8'd2) begin bad++; $display("FAIL eret_outside_state got=%b/%0d want=1/2", in_handler, exc_count); end
        cyc();
        total++; if (ctrl !== 12'h054 || in_handler !== 1'b0) begin bad++; $display("FAIL eret_second got=%h/%b want=054/0", ctrl, in_handler); end
        op = 11'h5A8;
        cyc();
        total++; if (ctrl !== 12'h000 || exc_req !== 1'b1 || exc_cause !== 2'b01) begin bad++; $display("FAIL cbz_edge got=%h/%b/%b want=000/1/01", ctrl, exc_req, exc_cause); end
        op = 11'h6B0;
        cyc();
`ifdef DECODE_STAGE_BR_EN
        total++; if (ctrl !== 12'h064 || exc_req !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL br got=%h/%b/%b want=064/0/0", ctrl, exc_req, halted); end
`else
        total++; if (ctrl !== 12'h000 || exc_cause !== 2'b11 || halted !== 1'b1) begin bad++; $display("FAIL br_off got=%h/%b/%b want=000/11/1", ctrl, exc_cause, halted); end
`endif
        do_reset();
    endtask

    task automatic test_nested_and_saturate;
        in_valid = 1'b1;
        op = 11'h000;
        cyc();
        op = 11'h7FF;
        cyc();
        total++; if (exc_req !== 1'b1 || exc_cause !== 2'b11 || halted !== 1'b1) begin bad++; $display("FAIL nested_halt got=%b/%b/%b want=1/11/1", exc_req, exc_cause, halted); end
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL nested_ready got=%b/%b want=0/1", in_ready, out_valid); end
        total++; if (exc_count2 !== 2'd2 || halted2 !== 1'b0 || in_handler2 !== 1'b1 || exc_cause2 !== 2'b11) begin bad++; $display("FAIL nested_nohalt got=%0d/%b/%b/%b want=2/0/1/11", exc_count2, halted2, in_handler2, exc_cause2); end
        repeat (3) cyc();
        total++; if (exc_count2 !== 2'd3) begin bad++; $display("FAIL saturate got=%0d want=3", exc_count2); end
        total++; if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || exc_count !== 8'd2) begin bad++; $display("FAIL halt_hold got=%b/%b/%b/%0d want=1/0/0/2", halted, in_ready, out_valid, exc_count); end
        op = 11'h458;
        cyc();
        #3;
        reset = 1'b0;
        #1;
        total++; if (out_valid2 !== 1'b0 || ctrl2 !== 12'h000 || exc_req2 !== 1'b0) begin bad++; $display("FAIL async_out got=%b/%h/%b want=0/000/0", out_valid2, ctrl2, exc_req2); end
        total++; if (exc_count2 !== 2'd0 || exc_cause2 !== 2'b00 || in_handler2 !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL async_state got=%0d/%b/%b/%b want=0/00/0/0", exc_count2, exc_cause2, in_handler2, halted); end
        #2;
        reset = 1'b1;
        op = 11'h7C2;
        cyc();
        total++; if (out_valid !== 1'b1 || ctrl !== 12'h701) begin bad++; $display("FAIL first_accept got=%b/%h want=1/701", out_valid, ctrl); end
        do_reset();
    endtask

    task automatic test_backpressure;
        in_valid = 1'b1;
        op = 11'h658;
        cyc();
        out_ready = 1'b0;
        op = 11'h7C2;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (out_valid !== 1'b1 || ctrl !== 12'h208 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b want=1/208/0", i, out_valid, ctrl, in_ready); end
        end
        out_ready = 1'b1;
        cyc();
        total++; if (out_valid !== 1'b1 || ctrl !== 12'h701) begin bad++; $display("FAIL bp_release got=%b/%h want=1/701", out_valid, ctrl); end
        op = 11'h000;
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (exc_req !== 1'b1) begin bad++; $display("FAIL bp_exc_rise got=%b want=1", exc_req); end
        cyc();
        total++; if (exc_req !== 1'b0 || out_valid !== 1'b1 || ctrl !== 12'h000) begin bad++; $display("FAIL bp_exc_pulse got=%b/%b/%h want=0/1/000", exc_req, out_valid, ctrl); end
        do_reset();
    endtask

    task automatic test_flush;
        in_valid = 1'b1;
        flush = 1'b1;
        op = 11'h000;
        cyc();
        total++; if (out_valid !== 1'b0 || exc_req !== 1'b0) begin bad++; $display("FAIL flush_accept got=%b/%b want=0/0", out_valid, exc_req); end
        total++; if (in_handler !== 1'b0 || exc_count !== 8'd0) begin bad++; $display("FAIL flush_fsm got=%b/%0d want=0/0", in_handler, exc_count); end
        flush = 1'b0;
        op = 11'h458;
        cyc();
        total++; if (out_valid !== 1'b1 || ctrl !== 12'h208) begin bad++; $display("FAIL flush_after got=%b/%h want=1/208", out_valid, ctrl); end
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_pending got=%b want=0", out_valid); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_handler();
        test_nested_and_saturate();
        test_backpressure();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
